// File: rtl/keypad_scanner.sv
// 4x4 active-low matrix keypad scanner: row synchroniser, column scan, press/release debounce.
// Optional auto-repeat while a key is held is enabled by defining KEYPAD_REPEAT_EN.
module keypad_scanner #(
  parameter int SCAN_DIV        = 1000,
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int REPEAT_CYCLES   = 5000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  row,
  output logic [3:0]  col,
  output logic        key_pressed,
  output logic [24:0] keypad_out
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int DEB_W = $clog2(DEBOUNCE_CYCLES);
  localparam int CNT_W = (DIV_W > DEB_W) ? DIV_W : DEB_W;

  if (SCAN_DIV < 4 || DEBOUNCE_CYCLES < 2 || REPEAT_CYCLES < 1) begin : g_param_check
    $error("keypad_scanner: parameter out of range");
  end

  typedef enum logic [1:0] {
    SCAN        = 2'd0,
    DEB_PRESS   = 2'd1,
    PRESSED     = 2'd2,
    DEB_RELEASE = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [3:0]         sync1_q;
  logic [3:0]         rs_q;
  logic [1:0]         col_idx_q, col_idx_d;
  logic [1:0]         row_idx_q, row_idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               kp_q, kp_d;
  logic [3:0]         code_q, code_d;
  logic [1:0]         low_row;
  logic               row_high;

`ifdef KEYPAD_REPEAT_EN
  localparam int HOLD_W = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic [2:0]         gap_q, gap_d;
  logic               in_gap_q, in_gap_d;
`endif

  function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] k;
    case ({r, c})
      4'b00_00: k = 4'h1;
      4'b00_01: k = 4'h2;
      4'b00_10: k = 4'h3;
      4'b00_11: k = 4'hA;
      4'b01_00: k = 4'h4;
      4'b01_01: k = 4'h5;
      4'b01_10: k = 4'h6;
      4'b01_11: k = 4'hB;
      4'b10_00: k = 4'h7;
      4'b10_01: k = 4'h8;
      4'b10_10: k = 4'h9;
      4'b10_11: k = 4'hC;
      4'b11_00: k = 4'hF;
      4'b11_01: k = 4'h0;
      4'b11_10: k = 4'hE;
      default:  k = 4'hD;
    endcase
    return k;
  endfunction

  // Lowest active row wins when several keys in the driven column are down.
  always_comb begin
    low_row = 2'd3;
    if (!rs_q[0])      low_row = 2'd0;
    else if (!rs_q[1]) low_row = 2'd1;
    else if (!rs_q[2]) low_row = 2'd2;
  end

  assign row_high = rs_q[row_idx_q];

  always_comb begin
    state_d   = state_q;
    col_idx_d = col_idx_q;
    row_idx_d = row_idx_q;
    cnt_d     = cnt_q;
    kp_d      = kp_q;
    code_d    = code_q;
`ifdef KEYPAD_REPEAT_EN
    hold_d    = hold_q;
    gap_d     = gap_q;
    in_gap_d  = in_gap_q;
`endif
    case (state_q)
      SCAN: begin
        if (cnt_q == CNT_W'(SCAN_DIV - 1)) begin
          cnt_d = '0;
          if (rs_q != 4'hF) begin
            row_idx_d = low_row;
            state_d   = DEB_PRESS;
          end else begin
            col_idx_d = col_idx_q + 2'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DEB_PRESS: begin
        if (row_high) begin
          cnt_d     = '0;
          col_idx_d = col_idx_q + 2'd1;
          state_d   = SCAN;
        end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          cnt_d   = '0;
          kp_d    = 1'b1;
          code_d  = key_code(row_idx_q, col_idx_q);
          state_d = PRESSED;
`ifdef KEYPAD_REPEAT_EN
          hold_d   = '0;
          in_gap_d = 1'b0;
`endif
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      PRESSED: begin
        if (row_high) begin
          cnt_d   = '0;
          state_d = DEB_RELEASE;
        end else begin
`ifdef KEYPAD_REPEAT_EN
          // The repeat gap is exactly 8 cycles; the next hold period starts when it ends.
          if (in_gap_q) begin
            if (gap_q == 3'd7) begin
              in_gap_d = 1'b0;
              kp_d     = 1'b1;
              hold_d   = '0;
            end else begin
              gap_d = gap_q + 3'd1;
            end
          end else if (hold_q == HOLD_W'(REPEAT_CYCLES - 1)) begin
            in_gap_d = 1'b1;
            gap_d    = 3'd0;
            kp_d     = 1'b0;
            hold_d   = '0;
          end else begin
            hold_d = hold_q + HOLD_W'(1);
          end
`endif
        end
      end
      DEB_RELEASE: begin
        if (!row_high) begin
          cnt_d   = '0;
          state_d = PRESSED;
`ifdef KEYPAD_REPEAT_EN
          kp_d     = 1'b1;
          hold_d   = '0;
          in_gap_d = 1'b0;
`endif
        end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          cnt_d     = '0;
          kp_d      = 1'b0;
          col_idx_d = col_idx_q + 2'd1;
          state_d   = SCAN;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = SCAN;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q   <= 4'hF;
      rs_q      <= 4'hF;
      state_q   <= SCAN;
      col_idx_q <= 2'd0;
      row_idx_q <= 2'd0;
      cnt_q     <= '0;
      kp_q      <= 1'b0;
      code_q    <= 4'h0;
    end else begin
      sync1_q   <= row;
      rs_q      <= sync1_q;
      state_q   <= state_d;
      col_idx_q <= col_idx_d;
      row_idx_q <= row_idx_d;
      cnt_q     <= cnt_d;
      kp_q      <= kp_d;
      code_q    <= code_d;
    end
  end

`ifdef KEYPAD_REPEAT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_q   <= '0;
      gap_q    <= 3'd0;
      in_gap_q <= 1'b0;
    end else begin
      hold_q   <= hold_d;
      gap_q    <= gap_d;
      in_gap_q <= in_gap_d;
    end
  end
`endif

  assign col         = ~(4'b0001 << col_idx_q);
  assign key_pressed = kp_q;
  assign keypad_out  = {21'd0, code_q};

endmodule
